// File: rtl/input_port_ctrl.sv
// rtl/input_port_ctrl.sv - mesh router input port: flit FIFO, XY route, allocator request/grant, crossbar launch
module input_port_ctrl #(
  parameter int FLIT_W  = 32,
  parameter int COORD_W = 3,
  parameter int DEPTH   = 4,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_data,
  output logic              in_ready,
  output logic [2:0]        targ,
  input  logic [2:0]        grant,
  output logic              pop,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_data,
  output logic [2:0]        out_dir
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_LOCAL = 3'd1;
  localparam logic [2:0] DIR_EAST  = 3'd2;
  localparam logic [2:0] DIR_WEST  = 3'd3;
  localparam logic [2:0] DIR_NORTH = 3'd4;
  localparam logic [2:0] DIR_SOUTH = 3'd5;

  localparam logic [COORD_W-1:0] MY_XC = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_YC = COORD_W'(MY_Y);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t state, state_nxt;

  logic [FLIT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic [FLIT_W-1:0]  head;
  logic [COORD_W-1:0] dest_x, dest_y;
  logic [2:0]         route;

  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign dest_x   = head[FLIT_W-1 -: COORD_W];
  assign dest_y   = head[FLIT_W-1-COORD_W -: COORD_W];

  always_comb begin
    route = DIR_LOCAL;
    if (dest_x > MY_XC)      route = DIR_EAST;
    else if (dest_x < MY_XC) route = DIR_WEST;
    else if (dest_y > MY_YC) route = DIR_NORTH;
    else if (dest_y < MY_YC) route = DIR_SOUTH;
  end

  // Storage has no reset: emptiness is tracked entirely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // HOLD masks the grant that the allocator registered against the head just popped.
  always_comb begin
    state_nxt = state;
    targ      = DIR_NONE;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) state_nxt = REQ;
      end
      REQ: begin
        targ = route;
        if ((grant == route) && (grant != DIR_NONE)) begin
          pop       = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        state_nxt = (count != '0) ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dir   <= DIR_NONE;
    end else begin
      out_valid <= pop;
      if (pop) begin
        out_data <= head;
        out_dir  <= targ;
      end
    end
  end

endmodule

// File: tb/tb_input_port_ctrl.sv
// tb/tb_input_port_ctrl.sv - directed self-checking bench for input_port_ctrl at router (2,2)
module tb_input_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [2:0]  targ;
  logic [2:0]  grant;
  logic        pop;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_dir;

  int n_cmp = 0;
  int n_bad = 0;

  input_port_ctrl #(
    .FLIT_W(32), .COORD_W(3), .DEPTH(4), .MY_X(2), .MY_Y(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .targ(targ), .grant(grant), .pop(pop), .out_valid(out_valid), .out_data(out_data),
    .out_dir(out_dir)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input int x, input int y, input int p);
    logic [31:0] xv, yv, pv;
    xv = x; yv = y; pv = p;
    return {xv[2:0], yv[2:0], pv[25:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; grant = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (targ !== 3'd0) begin n_bad++; $display("FAIL reset_targ got %0d exp 0", targ); end
    n_cmp++; if (pop !== 1'b0) begin n_bad++; $display("FAIL reset_pop got %b exp 0", pop); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    n_cmp++; if (out_dir !== 3'd0) begin n_bad++; $display("FAIL reset_out_dir got %0d exp 0", out_dir); end
    tick();
    n_cmp++; if (targ !== 3'd0) begin n_bad++; $display("FAIL reset_idle_targ got %0d exp 0", targ); end
    // two flits queued, then reset mid-stream
    in_valid = 1'b1; in_data = mk(3, 0, 1); tick();
    in_data = mk(3, 0, 2); tick();
    in_valid = 1'b0;
    n_cmp++; if (targ !== 3'd2) begin n_bad++; $display("FAIL pre_reset_targ got %0d exp 2", targ); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (targ !== 3'd0) begin n_bad++; $display("FAIL midrst_targ got %0d exp 0", targ); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (dut.count !== 3'd0) begin n_bad++; $display("FAIL midrst_count got %0d exp 0", dut.count); end
    grant = 3'd2;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (pop !== 1'b0) begin n_bad++; $display("FAIL postrst_pop cycle %0d got %b exp 0", i, pop); end
      n_cmp++; if (targ !== 3'd0) begin n_bad++; $display("FAIL postrst_targ cycle %0d got %0d exp 0", i, targ); end
      tick();
    end
    grant = 3'd0;
  endtask

  task automatic test_routing();
    int rx [5] = '{3, 1, 2, 2, 2};
    int ry [5] = '{0, 3, 4, 0, 2};
    int rd [5] = '{2, 3, 4, 5, 1};
    logic [31:0] f;
    for (int i = 0; i < 5; i++) begin
      f = mk(rx[i], ry[i], 26'h1000 + i);
      in_valid = 1'b1; in_data = f; tick();
      in_valid = 1'b0;
      n_cmp++; if (targ !== 3'd0) begin n_bad++; $display("FAIL route_idle_%0d got %0d exp 0", i, targ); end
      tick();
      n_cmp++; if (targ !== rd[i][2:0]) begin n_bad++; $display("FAIL route_targ_%0d got %0d exp %0d", i, targ, rd[i]); end
      grant = rd[i][2:0];
      #1;
      n_cmp++; if (pop !== 1'b1) begin n_bad++; $display("FAIL route_pop_%0d got %b exp 1", i, pop); end
      tick();
      grant = 3'd0;
      n_cmp++; if (out_dir !== rd[i][2:0]) begin n_bad++; $display("FAIL route_out_dir_%0d got %0d exp %0d", i, out_dir, rd[i]); end
      n_cmp++; if (out_data !== f) begin n_bad++; $display("FAIL route_out_data_%0d got %h exp %h", i, out_data, f); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL route_out_valid_drop_%0d got %b exp 0", i, out_valid); end
    end
  endtask

  task automatic test_handshake();
    logic [31:0] h;
    h = mk(4, 1, 26'h155);
    in_valid = 1'b1; in_data = h; tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      grant = 3'd0;
      #1;
      n_cmp++; if (targ !== 3'd2) begin n_bad++; $display("FAIL hs_wait_targ_%0d got %0d exp 2", i, targ); end
      n_cmp++; if (pop !== 1'b0) begin n_bad++; $display("FAIL hs_wait_pop_%0d got %b exp 0", i, pop); end
      tick();
    end
    grant = 3'd2;
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_bad++; $display("FAIL hs_pop got %b exp 1", pop); end
    tick();
    grant = 3'd0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hs_out_valid got %b exp 1", out_valid); end
    n_cmp++; if (out_dir !== 3'd2) begin n_bad++; $display("FAIL hs_out_dir got %0d exp 2", out_dir); end
    n_cmp++; if (out_data !== h) begin n_bad++; $display("FAIL hs_out_data got %h exp %h", out_data, h); end
    n_cmp++; if (targ !== 3'd0) begin n_bad++; $display("FAIL hs_hold_targ got %0d exp 0", targ); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hs_out_valid_drop got %b exp 0", out_valid); end
    n_cmp++; if (targ !== 3'd0) begin n_bad++; $display("FAIL hs_idle_targ got %0d exp 0", targ); end
  endtask

  task automatic test_stale_grant();
    logic [31:0] a, b;
    a = mk(3, 1, 26'h0A1);
    b = mk(5, 2, 26'h0B2);
    in_valid = 1'b1; in_data = a; tick();
    in_data = b; tick();
    in_valid = 1'b0;
    grant = 3'd4;
    #1;
    n_cmp++; if (pop !== 1'b0) begin n_bad++; $display("FAIL wrong_grant_pop got %b exp 0", pop); end
    n_cmp++; if (targ !== 3'd2) begin n_bad++; $display("FAIL wrong_grant_targ got %0d exp 2", targ); end
    tick();
    grant = 3'd2;
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_bad++; $display("FAIL stale_first_pop got %b exp 1", pop); end
    tick();
    #1;
    n_cmp++; if (pop !== 1'b0) begin n_bad++; $display("FAIL stale_hold_pop got %b exp 0", pop); end
    n_cmp++; if (targ !== 3'd0) begin n_bad++; $display("FAIL stale_hold_targ got %0d exp 0", targ); end
    n_cmp++; if (out_data !== a) begin n_bad++; $display("FAIL stale_out_a got %h exp %h", out_data, a); end
    tick();
    grant = 3'd0;
    #1;
    n_cmp++; if (pop !== 1'b0) begin n_bad++; $display("FAIL stale_t2_pop got %b exp 0", pop); end
    n_cmp++; if (targ !== 3'd2) begin n_bad++; $display("FAIL stale_t2_targ got %0d exp 2", targ); end
    tick();
    grant = 3'd2;
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_bad++; $display("FAIL stale_t3_pop got %b exp 1", pop); end
    tick();
    grant = 3'd0;
    n_cmp++; if (out_data !== b) begin n_bad++; $display("FAIL stale_out_b got %h exp %h", out_data, b); end
    tick();
    tick();
    n_cmp++; if (targ !== 3'd0) begin n_bad++; $display("FAIL stale_idle_targ got %0d exp 0", targ); end
  endtask

  task automatic test_full_fifo();
    int fx [8] = '{3, 1, 2, 2, 2, 0, 4, 2};
    int fy [8] = '{0, 3, 4, 0, 2, 5, 1, 7};
    int fd [8] = '{2, 3, 4, 5, 1, 3, 2, 4};
    logic [31:0] fl [8];
    logic [2:0]  last_targ;
    int nxt_in, idx_out;
    for (int i = 0; i < 8; i++) fl[i] = mk(fx[i], fy[i], 26'h2000 + 16 * i);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = fl[i]; tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (dut.count !== 3'd4) begin n_bad++; $display("FAIL full_count got %0d exp 4", dut.count); end
    in_valid = 1'b1; in_data = mk(7, 7, 26'h3FFFFFF); tick();
    in_valid = 1'b0;
    n_cmp++; if (dut.count !== 3'd4) begin n_bad++; $display("FAIL full_ignored_count got %0d exp 4", dut.count); end
    n_cmp++; if (targ !== 3'd2) begin n_bad++; $display("FAIL full_head_targ got %0d exp 2", targ); end
    grant = 3'd2;
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_bad++; $display("FAIL full_pop0 got %b exp 1", pop); end
    tick();
    grant = 3'd0;
    n_cmp++; if (out_data !== fl[0]) begin n_bad++; $display("FAIL full_out0 got %h exp %h", out_data, fl[0]); end
    n_cmp++; if (dut.count !== 3'd3) begin n_bad++; $display("FAIL full_count_after_pop got %0d exp 3", dut.count); end
    tick();
    // pop the second flit and push a new one in the same cycle
    grant = 3'd3; in_valid = 1'b1; in_data = fl[4];
    #1;
    n_cmp++; if (pop !== 1'b1) begin n_bad++; $display("FAIL full_pop1 got %b exp 1", pop); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_pushpop_ready got %b exp 1", in_ready); end
    tick();
    grant = 3'd0; in_valid = 1'b0;
    n_cmp++; if (out_data !== fl[1]) begin n_bad++; $display("FAIL full_out1 got %h exp %h", out_data, fl[1]); end
    n_cmp++; if (out_dir !== 3'd3) begin n_bad++; $display("FAIL full_dir1 got %0d exp 3", out_dir); end
    n_cmp++; if (dut.count !== 3'd3) begin n_bad++; $display("FAIL full_pushpop_count got %0d exp 3", dut.count); end
    last_targ = 3'd0; nxt_in = 5; idx_out = 2;
    for (int cyc = 0; cyc < 100 && idx_out < 8; cyc++) begin
      grant = last_targ;
      if (nxt_in < 8 && in_ready === 1'b1) begin
        in_valid = 1'b1; in_data = fl[nxt_in]; nxt_in++;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      last_targ = targ;
      tick();
      if (out_valid === 1'b1) begin
        n_cmp++; if (out_data !== fl[idx_out]) begin n_bad++; $display("FAIL full_order_%0d got %h exp %h", idx_out, out_data, fl[idx_out]); end
        n_cmp++; if (out_dir !== fd[idx_out][2:0]) begin n_bad++; $display("FAIL full_dir_%0d got %0d exp %0d", idx_out, out_dir, fd[idx_out]); end
        idx_out++;
      end
    end
    in_valid = 1'b0; grant = 3'd0;
    n_cmp++; if (idx_out != 8) begin n_bad++; $display("FAIL full_drain_timeout got %0d flits exp 8", idx_out); end
    repeat (3) tick();
    n_cmp++; if (targ !== 3'd0) begin n_bad++; $display("FAIL full_idle_targ got %0d exp 0", targ); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g [3];
    logic [2:0]  last_targ;
    int pc [4];
    int npop, nout;
    for (int i = 0; i < 3; i++) g[i] = mk(6, i, 26'h3000 + i);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = g[i]; tick();
    end
    in_valid = 1'b0;
    last_targ = 3'd0; npop = 0; nout = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      grant = last_targ;
      #1;
      if (pop === 1'b1 && npop < 4) begin pc[npop] = cyc; npop++; end
      last_targ = targ;
      tick();
      if (out_valid === 1'b1 && nout < 3) begin
        n_cmp++; if (out_data !== g[nout]) begin n_bad++; $display("FAIL b2b_out_%0d got %h exp %h", nout, out_data, g[nout]); end
        nout++;
      end
    end
    grant = 3'd0;
    n_cmp++; if (npop != 3) begin n_bad++; $display("FAIL b2b_pop_count got %0d exp 3", npop); end
    if (npop >= 3) begin
      n_cmp++; if (pc[1] - pc[0] != 3) begin n_bad++; $display("FAIL b2b_gap1 got %0d exp 3", pc[1] - pc[0]); end
      n_cmp++; if (pc[2] - pc[1] != 3) begin n_bad++; $display("FAIL b2b_gap2 got %0d exp 3", pc[2] - pc[1]); end
    end
    n_cmp++; if (targ !== 3'd0) begin n_bad++; $display("FAIL b2b_idle_targ got %0d exp 0", targ); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_out_valid got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_handshake();
    test_stale_grant();
    test_full_fifo();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
